// File: rtl/lfsr_checker.sv
// Receive-side checker for the 4-bit XNOR LFSR pattern (taps 3,2, period 15).
// Optional resync on loss of lock is built when LFSR_CHK_LOSS_EN is defined.
module lfsr_checker #(
  parameter int unsigned ERR_CNT_W   = 8,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bit_in_i,
  input  logic                 bit_valid_i,
  input  logic                 clr_count_i,
  output logic                 locked_o,
  output logic                 err_pulse_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  typedef enum logic {StSeed, StLocked} state_e;

  localparam logic [ERR_CNT_W-1:0] CntMax = '1;

  if (LOSS_THRESH < 1 || LOSS_THRESH > 15) begin : g_bad_thresh
    $error("LOSS_THRESH must be in 1..15");
  end

  state_e               state_q;
  logic [3:0]           s_q;
  logic [1:0]           seed_cnt_q;
  logic                 locked_q;
  logic                 err_pulse_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic       exp_bit;
  logic       mismatch;
  logic [3:0] seed_next;

  always_comb begin
    exp_bit   = ~(s_q[3] ^ s_q[2]);
    mismatch  = bit_in_i != exp_bit;
    seed_next = {s_q[2:0], bit_in_i};
  end

`ifdef LFSR_CHK_LOSS_EN
  localparam logic [3:0] LossThresh = 4'(LOSS_THRESH);

  logic [3:0] consec_q;
  logic [3:0] consec_inc;
  logic       loss;

  always_comb begin
    consec_inc = (consec_q == 4'hF) ? 4'hF : consec_q + 4'd1;
    loss       = mismatch && (consec_inc >= LossThresh);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StSeed;
      s_q         <= 4'b0000;
      seed_cnt_q  <= 2'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
`ifdef LFSR_CHK_LOSS_EN
      consec_q    <= 4'd0;
`endif
    end else begin
      err_pulse_q <= 1'b0;
      if (clr_count_i) begin
        err_count_q <= '0;
      end
      if (bit_valid_i) begin
        unique case (state_q)
          StSeed: begin
            s_q <= seed_next;
            if (seed_cnt_q == 2'd3) begin
              seed_cnt_q <= 2'd0;
              // 1111 is the XNOR lockup state; it can only come from a corrupt seed
              if (seed_next != 4'hF) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end
            end else begin
              seed_cnt_q <= seed_cnt_q + 2'd1;
            end
          end
          StLocked: begin
            // Free-run on the prediction so a single bad bit costs a single error
            s_q <= {s_q[2:0], exp_bit};
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              if (!clr_count_i && err_count_q != CntMax) begin
                err_count_q <= err_count_q + ERR_CNT_W'(1);
              end
            end
`ifdef LFSR_CHK_LOSS_EN
            if (loss) begin
              state_q    <= StSeed;
              locked_q   <= 1'b0;
              seed_cnt_q <= 2'd0;
              consec_q   <= 4'd0;
            end else begin
              consec_q <= mismatch ? consec_inc : 4'd0;
            end
`endif
          end
        endcase
      end
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: vector table, directed corner sequences and
// randomized traffic against a phase-indexed golden-sequence reference model.
module tb_lfsr_checker;

  localparam int unsigned CntW   = 8;
  localparam int unsigned Thresh = 4;
  localparam int          CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            bit_in = 1'b0;
  logic            bit_valid = 1'b0;
  logic            clr_count = 1'b0;
  logic            locked;
  logic            err_pulse;
  logic [CntW-1:0] err_count;

  always #5 clk = ~clk;

  lfsr_checker #(
    .ERR_CNT_W  (CntW),
    .LOSS_THRESH(Thresh)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bit_in_i   (bit_in),
    .bit_valid_i(bit_valid),
    .clr_count_i(clr_count),
    .locked_o   (locked),
    .err_pulse_o(err_pulse),
    .err_count_o(err_count)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  string tag = "";

  bit golden[15] = '{1, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0};

  // Reference model: once locked, expected bits are the golden sequence read from the
  // phase that the four seed bits identify.
  bit m_locked;
  bit m_pulse;
  int m_cnt;
  int m_idx;
  int m_consec;
  bit seed_q[$];

  function automatic bit gold(input int k);
    return golden[k % 15];
  endfunction

  function automatic int phase_of(input bit b0, input bit b1, input bit b2, input bit b3);
    for (int p = 0; p < 15; p++) begin
      if (gold(p) == b0 && gold(p + 1) == b1 && gold(p + 2) == b2 && gold(p + 3) == b3)
        return p;
    end
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit b, input bit c);
    bit e;
    if (r) begin
      m_locked = 0; m_pulse = 0; m_cnt = 0; m_idx = 0; m_consec = 0;
      seed_q.delete();
      return;
    end
    m_pulse = 0;
    if (c) m_cnt = 0;
    if (!v) return;
    if (!m_locked) begin
      seed_q.push_back(b);
      if (seed_q.size() == 4) begin
        if (!(seed_q[0] && seed_q[1] && seed_q[2] && seed_q[3])) begin
          m_idx    = (phase_of(seed_q[0], seed_q[1], seed_q[2], seed_q[3]) + 4) % 15;
          m_locked = 1;
        end
        seed_q.delete();
      end
    end else begin
      e     = golden[m_idx];
      m_idx = (m_idx + 1) % 15;
      if (b != e) begin
        m_pulse = 1;
        if (!c && m_cnt < CntMax) m_cnt++;
        if (m_consec < 15) m_consec++;
`ifdef LFSR_CHK_LOSS_EN
        if (m_consec >= Thresh) begin
          m_locked = 0;
          m_consec = 0;
          seed_q.delete();
        end
`endif
      end else begin
        m_consec = 0;
      end
    end
  endtask

  // Called at a negedge: drive, let the DUT sample, then compare at the next negedge.
  task automatic cycle(input bit r, input bit v, input bit b, input bit c);
    rst = r; bit_valid = v; bit_in = b; clr_count = c;
    @(posedge clk);
    model_step(r, v, b, c);
    @(negedge clk);
    check("locked", int'(locked), int'(m_locked));
    check("err_pulse", int'(err_pulse), int'(m_pulse));
    check("err_count", int'(err_count), m_cnt);
    if (err_pulse) pulses++;
  endtask

  typedef struct {
    bit r, v, b, c;
    bit lk, pl;
    int cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int k;
    int ph;
    int burst;
    bit rr, vv, cc, fl;

    // Lockup-seed scenario followed by an error, a clear and a valid gap.
    tbl.push_back(vec_t'{1, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 1, 1, 1});
    tbl.push_back(vec_t'{0, 1, 0, 0, 1, 0, 1});
    tbl.push_back(vec_t'{0, 0, 0, 1, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 0, 1, 0, 0});

    @(negedge clk);

    tag = "reset";
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);
    check("rst_locked", int'(locked), 0);
    check("rst_pulse", int'(err_pulse), 0);
    check("rst_count", int'(err_count), 0);

    tag = "clean";
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      cycle(0, 1, gold(i), 0);
      if (i == 2) check("not_locked_bit3", int'(locked), 0);
      if (i == 3) check("locked_bit4", int'(locked), 1);
    end
    check("end_locked", int'(locked), 1);
    check("no_pulses", pulses, 0);
    check("end_count", int'(err_count), 0);

    tag = "flip";
    cycle(1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      cycle(0, 1, gold(i) ^ (i == 9), 0);
      if (i == 9) check("pulse_after_bit10", int'(err_pulse), 1);
    end
    check("one_pulse", pulses, 1);
    check("count_one", int'(err_count), 1);
    check("still_locked", int'(locked), 1);

    tag = "table";
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].c);
      check($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].lk));
      check($sformatf("vec%0d_pulse", i), int'(err_pulse), int'(tbl[i].pl));
      check($sformatf("vec%0d_count", i), int'(err_count), tbl[i].cnt);
    end

    tag = "loss";
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, gold(i), 0);
    pulses = 0;
    for (k = 4; k < 12; k++) begin
      cycle(0, 1, !gold(k), 0);
`ifdef LFSR_CHK_LOSS_EN
      if (k == 6) check("locked_before_4th", int'(locked), 1);
      if (k == 7) begin
        check("unlocked_4th", int'(locked), 0);
        check("pulse_4th", int'(err_pulse), 1);
        check("count_4", int'(err_count), 4);
        check("pulses_4", pulses, 4);
      end
`endif
    end
`ifndef LFSR_CHK_LOSS_EN
    check("stays_locked", int'(locked), 1);
    check("count_8", int'(err_count), 8);
    check("pulses_8", pulses, 8);

    tag = "saturate";
    for (int i = 0; i < 260; i++) begin
      cycle(0, 1, !gold(k), 0);
      k++;
    end
    check("count_held", int'(err_count), CntMax);
`endif

    tag = "clr_err";
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, gold(i + 3), 0);
    cycle(0, 1, !gold(7), 0);
    check("count_pre", int'(err_count), 1);
    cycle(0, 1, !gold(8), 1);
    check("clr_wins", int'(err_count), 0);
    check("pulse_kept", int'(err_pulse), 1);

    tag = "gaps";
    cycle(1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, gold(i), 0);
      cycle(0, 0, 1'($urandom), 0);
    end
    check("gap_locked", int'(locked), 1);
    check("gap_no_pulse", pulses, 0);
    cycle(0, 1, !gold(20), 0);
    check("gap_err_count", int'(err_count), 1);
    cycle(1, 1, 1, 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_pulse", int'(err_pulse), 0);
    check("midrst_count", int'(err_count), 0);
    pulses = 0;
    for (int i = 7; i < 21; i++) begin
      cycle(0, 1, gold(i), 0);
      if (i == 9) check("reseed_bit3", int'(locked), 0);
      if (i == 10) check("reseed_bit4", int'(locked), 1);
    end
    check("reseed_no_pulse", pulses, 0);

    tag = "random";
    ph = 0;
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      vv = ($urandom_range(0, 3) != 0);
      cc = ($urandom_range(0, 49) == 0);
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(1, 6);
      fl = (burst > 0) || ($urandom_range(0, 99) < 2);
      cycle(rr, vv, gold(ph) ^ fl, cc);
      if (vv) begin
        ph++;
        if (burst > 0) burst--;
      end
      if (rr) ph = $urandom_range(0, 14);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial receive-side checker for the 4-bit XNOR LFSR test pattern (taps 3,2, `fb = ~(s[3]^s[2])`, sequence period 15). It sits at the far end of a serial link or loopback, consuming one bit per valid cycle. It self-synchronizes by seeding its own LFSR from the first four received bits, then predicts every following bit and flags mismatches. Outputs are lock status, a per-bit error pulse and a saturating error count for bring-up and BIST.

## Interface
- `ERR_CNT_W`, 8: width of the error counter.
- `LOSS_THRESH`, 4: number of consecutive errors that forces a resync. Legal range is 1..15. Used only with `LFSR_CHK_LOSS_EN`.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `bit_in` input 1: received serial bit.
- `bit_valid` input 1: qualifies `bit_in` in this cycle.
- `clr_count` input 1: synchronous clear of `err_count`.
- `locked` output 1: checker is in LOCKED state.
- `err_pulse` output 1: one-cycle flag that the previous valid bit mismatched.
- `err_count` output `ERR_CNT_W`: saturating count of mismatched bits.

## Operation
- **State register `s[3:0]` and FSM** with two states:
  - SEED: `s` collects received bits.
  - LOCKED: `s` runs freely from its predictions.
- **Reset** (`rst` high at an edge):
  - state = SEED, `s` = 0000, `seed_cnt` = 0, `consec` = 0.
  - `locked` = 0, `err_pulse` = 0, `err_count` = 0.
  - `rst` overrides every other input.
- **SEED state**, on each valid cycle:
  - `s <= {s[2:0], bit_in}` and `seed_cnt` increments.
  - On the 4th valid bit, if the new `s` ≠ 1111, go to LOCKED.
  - If the new `s` = 1111 (the XNOR lockup state, which never occurs in a legal stream), stay in SEED and set `seed_cnt` = 0.
  - No errors are counted in SEED.
- **LOCKED state**, on each valid cycle:
  - `exp = ~(s[3]^s[2])`, then `s <= {s[2:0], exp}`.
  - The shift uses the predicted bit, never `bit_in`, so one corrupted bit produces exactly one error.
  - If `bit_in != exp`: `err_pulse` = 1, `err_count` increments (saturating at all-ones), `consec` increments (saturating at 15).
  - If `bit_in == exp`: `consec` = 0.
- **`bit_valid` low**: state, `s`, `seed_cnt`, `consec` and `err_count` hold; `err_pulse` = 0.
- **`clr_count`**:
  - Sets `err_count` = 0 at the next edge, in any state.
  - When it coincides with an error, clear wins and `err_count` = 0; `err_pulse` still fires.
- **`err_count` arithmetic**: unsigned, `ERR_CNT_W` bits, holds at 2^`ERR_CNT_W`−1 and never wraps.

## Timing
- All outputs are registered.
- `locked` rises at the edge that samples the 4th seed bit, i.e. it is visible in the cycle after that bit.
- `err_pulse` is high for exactly the one cycle after the edge that sampled the erroneous bit.
- `err_count` updates on that same edge.
- Back-to-back valid bits are supported at one bit per cycle. There is no backpressure.
- On resync (`LFSR_CHK_LOSS_EN`):
  - `locked` falls at the edge that samples the `LOSS_THRESH`-th consecutive error; `err_pulse` is also high for that error.
  - `seed_cnt` = 0 and `consec` = 0; `err_count` keeps its value.
  - The next four valid bits reseed `s`.

## Configuration
- `LFSR_CHK_LOSS_EN` defined:
  - When `consec` reaches `LOSS_THRESH` in LOCKED, the FSM returns to SEED as described under Timing.
- `LFSR_CHK_LOSS_EN` undefined:
  - The `consec` logic is not built and `LOSS_THRESH` is ignored.
  - Once LOCKED, the FSM stays LOCKED until `rst`.
  - Continuous errors only increment `err_count` and pulse `err_pulse`.

## Test plan
Golden stream is the generator output from 0000: 1,1,1,0,1,1,0,0,1,0,1,0,0,0,0, repeating.
- **Clean lock**: after `rst`, drive 45 golden bits with `bit_valid`=1 -> `locked`=1 from the cycle after bit 4, `err_pulse` never high, `err_count`=0.
- **Single flip**: same stream with bit 10 inverted -> exactly one `err_pulse` (cycle after bit 10), `err_count`=1, `locked` stays 1.
- **Lockup seed**: after `rst`, drive 1,1,1,1, then golden bits 5..8 (1,1,0,0) -> `locked`=0 after the first four bits, `locked`=1 after bit 8.
- **Loss of lock**: with `LFSR_CHK_LOSS_EN` and `LOSS_THRESH`=4, lock, then drive the inverted stream -> 4 pulses, `locked` falls on the 4th error, `err_count`=4.
  - With the macro undefined: `locked` stays 1 and `err_count` keeps counting.
- **Saturation and clear**: `ERR_CNT_W`=2, lock, drive 5 inverted bits -> `err_count`=3 (held).
  - Then assert `clr_count` together with a 6th error -> `err_count`=0 and `err_pulse`=1.
- **Valid gaps and mid-run reset**: lock with `bit_valid` toggling 1,0,1,0 -> no spurious errors.
  - Then `rst` for 1 cycle -> all outputs 0 and the FSM reseeds from the next 4 valid bits.
